wb_unit: RTL and testbench

- Writeback stage of the core; it is the write side of the regu register file.
- Merges single-cycle ALU results with buffered long-latency (load/div) responses and drives the regfile rd write port with registered outputs.
- Keeps a 32-entry pending-write scoreboard for long-latency destinations and raises a combinational stall to id on RAW or WAW hazards against those destinations.

---
 rtl/wb_unit_pkg.sv | 21 ++
 rtl/wb_unit_if.sv | 52 +++++
 rtl/wb_result_fifo.sv | 76 +++++++
 rtl/wb_unit.sv | 141 ++++++++++++++
 tb/tb_wb_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared types and defaults for the writeback stage.
//   WB_XLEN / WB_REG_AW / WB_LQ_DEPTH : default parameter values
//   wb_src_e                          : which source drives the regfile write
//   wb_cnt_width()                    : width of an occupancy counter 0..depth
package wb_unit_pkg;

  localparam int WB_XLEN     = 32;
  localparam int WB_REG_AW   = 5;
  localparam int WB_LQ_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LQ   = 2'd2
  } wb_src_e;

  function automatic int wb_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: bundles every non-clock signal of the writeback stage.
//   slave  : wb_unit side (consumes ALU/long-latency/id inputs, drives
//            lu_ready_o, stall_o, regu_rd_* and err_o)
//   master : environment side (the opposite directions)
interface wb_unit_if
  import wb_unit_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW
);

  logic              alu_valid_i;
  logic [REG_AW-1:0] alu_rd_addr_i;
  logic [XLEN-1:0]   alu_rd_data_i;

  logic              lu_issue_i;
  logic [REG_AW-1:0] lu_issue_rd_i;
  logic              lu_valid_i;
  logic [REG_AW-1:0] lu_rd_i;
  logic [XLEN-1:0]   lu_data_i;
  logic              lu_ready_o;

  logic [REG_AW-1:0] id_rs1_addr_i;
  logic [REG_AW-1:0] id_rs2_addr_i;
  logic [REG_AW-1:0] id_rd_addr_i;
  logic              id_rd_wr_en_i;
  logic              stall_o;

  logic [REG_AW-1:0] regu_rd_addr_o;
  logic [XLEN-1:0]   regu_rd_data_o;
  logic              regu_rd_wr_en_o;
  logic              err_o;

  modport slave (
    input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    input  lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o,
    input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_rd_wr_en_i,
    output stall_o,
    output regu_rd_addr_o, regu_rd_data_o, regu_rd_wr_en_o, err_o
  );

  modport master (
    output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    output lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o,
    output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_rd_wr_en_i,
    input  stall_o,
    input  regu_rd_addr_o, regu_rd_data_o, regu_rd_wr_en_o, err_o
  );

endinterface

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small synchronous FIFO buffering long-latency results.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   data_i     : entry to write
//   data_o     : current head entry (valid when !empty_o)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : number of stored entries
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_result_fifo
  import wb_unit_pkg::*;
#(
  parameter int DEPTH = WB_LQ_DEPTH,
  parameter int WIDTH = WB_REG_AW + WB_XLEN,
  localparam int CNT_W = wb_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy update; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage, write side of the regu register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_unit_if.slave
//     alu_*      single-cycle results, never back-pressured
//     lu_issue_* long-latency op leaving id (marks its rd pending)
//     lu_*       long-latency responses, accepted on lu_valid_i && lu_ready_o
//     id_*       id operands/destination checked for hazards -> stall_o
//     regu_rd_*  registered regfile write port
//     err_o      sticky protocol error
// ALU results have priority; buffered responses drain in idle ALU slots.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN     = WB_XLEN,
  parameter int REG_AW   = WB_REG_AW,
  parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
  input logic     clk,
  input logic     rst_n,
  wb_unit_if.slave bus
);

  localparam int NREGS = 2 ** REG_AW;
  localparam int ENT_W = REG_AW + XLEN;
  localparam int CNT_W = wb_cnt_width(LQ_DEPTH);

  logic [NREGS-1:0]  sb_q, sb_d;
  logic              err_q, err_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_wr_en_q, rd_wr_en_d;

  logic              lq_push, lq_pop, lq_full, lq_empty;
  logic [ENT_W-1:0]  lq_wdata, lq_rdata;
  logic [CNT_W-1:0]  lq_count;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;

  logic    lu_ready, lu_accept, alu_wr, issue_set;
  logic    resp_orphan, issue_dup;
  logic    rs1_hit, rs2_hit, waw_hit;
  wb_src_e src;

  wb_result_fifo #(
    .DEPTH(LQ_DEPTH),
    .WIDTH(ENT_W)
  ) u_lq (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (lq_push),
    .pop_i  (lq_pop),
    .data_i (lq_wdata),
    .data_o (lq_rdata),
    .full_o (lq_full),
    .empty_o(lq_empty),
    .count_o(lq_count)
  );

  assign head_rd   = lq_rdata[ENT_W-1:XLEN];
  assign head_data = lq_rdata[XLEN-1:0];

  // Ready from the registered count only: a pop at full does not reopen
  // the FIFO in the same cycle.
  assign lu_ready  = (lq_count < CNT_W'(LQ_DEPTH));
  assign lu_accept = bus.lu_valid_i && lu_ready;
  // x0 responses are consumed but never buffered.
  assign lq_push   = lu_accept && (bus.lu_rd_i != '0) && !lq_full;
  assign lq_wdata  = {bus.lu_rd_i, bus.lu_data_i};

  assign alu_wr    = bus.alu_valid_i && (bus.alu_rd_addr_i != '0);
  assign issue_set = bus.lu_issue_i && (bus.lu_issue_rd_i != '0);

  // ALU wins the write port; an x0 ALU write leaves the slot free for the FIFO.
  always_comb begin
    src = WB_SRC_NONE;
    if (alu_wr)         src = WB_SRC_ALU;
    else if (!lq_empty) src = WB_SRC_LQ;
  end

  assign lq_pop = (src == WB_SRC_LQ);

  // Address/data hold their previous values on idle cycles.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_wr_en_d = 1'b0;
    case (src)
      WB_SRC_ALU: begin
        rd_addr_d  = bus.alu_rd_addr_i;
        rd_data_d  = bus.alu_rd_data_i;
        rd_wr_en_d = 1'b1;
      end
      WB_SRC_LQ: begin
        rd_addr_d  = head_rd;
        rd_data_d  = head_data;
        rd_wr_en_d = 1'b1;
      end
      default: rd_wr_en_d = 1'b0;
    endcase
  end

  // Set is applied after clear so a re-issue to the popped index stays pending.
  always_comb begin
    sb_d = sb_q;
    if (lq_pop)    sb_d[head_rd] = 1'b0;
    if (issue_set) sb_d[bus.lu_issue_rd_i] = 1'b1;
  end

  assign resp_orphan = lu_accept && (bus.lu_rd_i != '0) && !sb_q[bus.lu_rd_i];
  assign issue_dup   = issue_set && sb_q[bus.lu_issue_rd_i];
  assign err_d       = err_q || resp_orphan || issue_dup;

  // Hazards use the registered scoreboard, so stall lasts through the clear edge.
  assign rs1_hit = (bus.id_rs1_addr_i != '0) && sb_q[bus.id_rs1_addr_i];
  assign rs2_hit = (bus.id_rs2_addr_i != '0) && sb_q[bus.id_rs2_addr_i];
  assign waw_hit = bus.id_rd_wr_en_i && (bus.id_rd_addr_i != '0) && sb_q[bus.id_rd_addr_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q       <= '0;
      err_q      <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_wr_en_q <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      err_q      <= err_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_wr_en_q <= rd_wr_en_d;
    end
  end

  assign bus.lu_ready_o      = lu_ready;
  assign bus.stall_o         = rs1_hit || rs2_hit || waw_hit;
  assign bus.regu_rd_addr_o  = rd_addr_q;
  assign bus.regu_rd_data_o  = rd_data_q;
  assign bus.regu_rd_wr_en_o = rd_wr_en_q;
  assign bus.err_o           = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: self-checking bench for wb_unit.
// A directed table walks the main scenarios with hand-written expectations,
// short hand sequences cover reset, double issue and set-over-clear, then
// random traffic is compared against a queue-based reference model.
module tb_wb_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_unit_if #(.XLEN(32), .REG_AW(5)) wbIf ();

  wb_unit #(
    .XLEN(32),
    .REG_AW(5),
    .LQ_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (wbIf.slave)
  );

  int vectorCount = 0;
  int miscompares = 0;

  typedef struct {
    bit          aluV;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    bit          iss;
    logic [4:0]  issRd;
    bit          luV;
    logic [4:0]  luRd;
    logic [31:0] luData;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    bit          rdWe;
    bit          eStall;
    bit          eReady;
    bit          eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    bit          eErr;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: pending set, ordered response queue, expected port values.
  ent_t        mq[$];
  bit          pend[32];
  bit          mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  bit          mErr;

  vec_t tbl[$];

  function automatic vec_t mk(input int aluV, input int aluRd, input logic [31:0] aluData,
                              input int iss, input int issRd,
                              input int luV, input int luRd, input logic [31:0] luData,
                              input int rs1, input int rs2, input int rd, input int rdWe,
                              input int eStall, input int eReady,
                              input int eWe, input int eAddr, input logic [31:0] eData,
                              input int eErr);
    vec_t v;
    v.aluV = (aluV != 0);  v.aluRd = 5'(aluRd);  v.aluData = aluData;
    v.iss  = (iss != 0);   v.issRd = 5'(issRd);
    v.luV  = (luV != 0);   v.luRd  = 5'(luRd);   v.luData  = luData;
    v.rs1  = 5'(rs1);      v.rs2   = 5'(rs2);    v.rd      = 5'(rd);
    v.rdWe = (rdWe != 0);
    v.eStall = (eStall != 0); v.eReady = (eReady != 0);
    v.eWe  = (eWe != 0);   v.eAddr = 5'(eAddr);  v.eData = eData;
    v.eErr = (eErr != 0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wbIf.alu_valid_i   = v.aluV;
    wbIf.alu_rd_addr_i = v.aluRd;
    wbIf.alu_rd_data_i = v.aluData;
    wbIf.lu_issue_i    = v.iss;
    wbIf.lu_issue_rd_i = v.issRd;
    wbIf.lu_valid_i    = v.luV;
    wbIf.lu_rd_i       = v.luRd;
    wbIf.lu_data_i     = v.luData;
    wbIf.id_rs1_addr_i = v.rs1;
    wbIf.id_rs2_addr_i = v.rs2;
    wbIf.id_rd_addr_i  = v.rd;
    wbIf.id_rd_wr_en_i = v.rdWe;
  endtask

  task automatic idleInputs();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic modelReset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    mWe = 1'b0; mAddr = '0; mData = '0; mErr = 1'b0;
  endtask

  function automatic bit modelStall();
    bit s;
    s = 1'b0;
    if (wbIf.id_rs1_addr_i != 0 && pend[wbIf.id_rs1_addr_i]) s = 1'b1;
    if (wbIf.id_rs2_addr_i != 0 && pend[wbIf.id_rs2_addr_i]) s = 1'b1;
    if (wbIf.id_rd_wr_en_i && wbIf.id_rd_addr_i != 0 && pend[wbIf.id_rd_addr_i]) s = 1'b1;
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit   old[32];
    bit   acc;
    ent_t e;
    old = pend;
    acc = wbIf.lu_valid_i && (mq.size() < 2);
    if (wbIf.alu_valid_i && wbIf.alu_rd_addr_i != 0) begin
      mWe = 1'b1; mAddr = wbIf.alu_rd_addr_i; mData = wbIf.alu_rd_data_i;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      mWe = 1'b1; mAddr = e.rd; mData = e.data;
      pend[e.rd] = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    if (acc && wbIf.lu_rd_i != 0 && !old[wbIf.lu_rd_i]) mErr = 1'b1;
    if (wbIf.lu_issue_i && wbIf.lu_issue_rd_i != 0 && old[wbIf.lu_issue_rd_i]) mErr = 1'b1;
    if (acc && wbIf.lu_rd_i != 0) begin
      e.rd = wbIf.lu_rd_i; e.data = wbIf.lu_data_i;
      mq.push_back(e);
    end
    if (wbIf.lu_issue_i && wbIf.lu_issue_rd_i != 0) pend[wbIf.lu_issue_rd_i] = 1'b1;
  endtask

  // One checked clock: combinational outputs before the edge, registered after.
  task automatic cycle();
    #1;
    checkOutput("stall", 32'(wbIf.stall_o), 32'(modelStall()));
    checkOutput("lu_ready", 32'(wbIf.lu_ready_o), 32'(mq.size() < 2));
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("wr_en", 32'(wbIf.regu_rd_wr_en_o), 32'(mWe));
    checkOutput("wr_addr", 32'(wbIf.regu_rd_addr_o), 32'(mAddr));
    checkOutput("wr_data", wbIf.regu_rd_data_o, mData);
    checkOutput("err", 32'(wbIf.err_o), 32'(mErr));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_en", 32'(wbIf.regu_rd_wr_en_o), 32'd0);
    checkOutput("rst_addr", 32'(wbIf.regu_rd_addr_o), 32'd0);
    checkOutput("rst_data", wbIf.regu_rd_data_o, 32'd0);
    checkOutput("rst_err", 32'(wbIf.err_o), 32'd0);
    checkOutput("rst_stall", 32'(wbIf.stall_o), 32'd0);
    checkOutput("rst_ready", 32'(wbIf.lu_ready_o), 32'd1);
    modelReset();
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pl[$];
    vec_t v;

    rst_n = 1'b0;
    idleInputs();
    modelReset();
    #12;
    checkOutput("init_wr_en", 32'(wbIf.regu_rd_wr_en_o), 32'd0);
    checkOutput("init_err", 32'(wbIf.err_o), 32'd0);
    checkOutput("init_ready", 32'(wbIf.lu_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // aluV aluRd aluData iss issRd luV luRd luData rs1 rs2 rd rdWe | stall ready | we addr data err
    tbl.push_back(mk(1, 5, 'h1234, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1, 1, 5,  'h1234, 0));
    tbl.push_back(mk(1, 0, 'hFFFF, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1, 0, 5,  'h1234, 0));
    tbl.push_back(mk(0, 0, 0,      1, 7, 0, 0, 0,      7, 0, 0, 0, 0, 1, 0, 5,  'h1234, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      7, 0, 0, 0, 1, 1, 0, 5,  'h1234, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 1, 7, 'hDEAD, 7, 0, 0, 0, 1, 1, 0, 5,  'h1234, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      7, 0, 0, 0, 1, 1, 1, 7,  'hDEAD, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      7, 0, 0, 0, 0, 1, 0, 7,  'hDEAD, 0));
    tbl.push_back(mk(1, 1, 'h11,   1, 3, 0, 0, 0,      0, 0, 0, 0, 0, 1, 1, 1,  'h11,   0));
    tbl.push_back(mk(1, 1, 'h22,   1, 4, 0, 0, 0,      0, 0, 0, 0, 0, 1, 1, 1,  'h22,   0));
    tbl.push_back(mk(1, 2, 'h33,   0, 0, 1, 3, 'h333,  0, 0, 0, 0, 0, 1, 1, 2,  'h33,   0));
    tbl.push_back(mk(1, 2, 'h44,   0, 0, 1, 4, 'h444,  0, 0, 0, 0, 0, 1, 1, 2,  'h44,   0));
    tbl.push_back(mk(1, 2, 'h55,   0, 0, 1, 4, 'h999,  0, 0, 0, 0, 0, 0, 1, 2,  'h55,   0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      4, 0, 0, 0, 1, 0, 1, 3,  'h333,  0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      4, 0, 0, 0, 1, 1, 1, 4,  'h444,  0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 1, 0, 4,  'h444,  0));
    tbl.push_back(mk(0, 0, 0,      1, 9, 0, 0, 0,      0, 0, 0, 0, 0, 1, 0, 4,  'h444,  0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 9, 1, 1, 1, 0, 4,  'h444,  0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 9, 0, 0, 1, 0, 4,  'h444,  0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 1, 12, 'hC,   0, 0, 0, 0, 0, 1, 0, 4,  'h444,  1));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1, 1, 12, 'hC,    1));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 9, 1, 1, 1, 0, 12, 'hC,    1));
    tbl.push_back(mk(0, 0, 0,      0, 0, 1, 0, 'h77,   0, 0, 0, 0, 0, 1, 0, 12, 'hC,    1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("t%0d_stall", i), 32'(wbIf.stall_o), 32'(tbl[i].eStall));
      checkOutput($sformatf("t%0d_ready", i), 32'(wbIf.lu_ready_o), 32'(tbl[i].eReady));
      cycle();
      checkOutput($sformatf("t%0d_we", i), 32'(wbIf.regu_rd_wr_en_o), 32'(tbl[i].eWe));
      checkOutput($sformatf("t%0d_addr", i), 32'(wbIf.regu_rd_addr_o), 32'(tbl[i].eAddr));
      checkOutput($sformatf("t%0d_data", i), wbIf.regu_rd_data_o, tbl[i].eData);
      checkOutput($sformatf("t%0d_err", i), 32'(wbIf.err_o), 32'(tbl[i].eErr));
    end

    // Double issue to x2 from a clean state.
    idleInputs();
    doReset();
    applyStimulus(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    checkOutput("dbl_first_err", 32'(wbIf.err_o), 32'd0);
    cycle();
    checkOutput("dbl_second_err", 32'(wbIf.err_o), 32'd1);

    // Re-issue to x5 in the same cycle its response is popped: the bit stays set.
    idleInputs();
    doReset();
    applyStimulus(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 5, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    checkOutput("sw_we", 32'(wbIf.regu_rd_wr_en_o), 32'd1);
    checkOutput("sw_data", wbIf.regu_rd_data_o, 32'h55);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("sw_stall", 32'(wbIf.stall_o), 32'd1);
    cycle();

    // Fill the FIFO behind continuous ALU traffic, then reset asynchronously.
    idleInputs();
    doReset();
    applyStimulus(mk(1, 1, 'h1, 1, 10, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(1, 1, 'h2, 1, 11, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(1, 1, 'h3, 1, 12, 1, 10, 'hA,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(1, 1, 'h4, 0, 0,  1, 11, 'hB,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(1, 1, 'h5, 0, 0,  0, 0, 0,     12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("full_ready", 32'(wbIf.lu_ready_o), 32'd0);
    checkOutput("full_stall", 32'(wbIf.stall_o), 32'd1);
    cycle();
    doReset();
    wbIf.id_rs1_addr_i = 5'd12;
    #1;
    checkOutput("post_rst_stall", 32'(wbIf.stall_o), 32'd0);
    checkOutput("post_rst_ready", 32'(wbIf.lu_ready_o), 32'd1);
    cycle();

    // Random traffic against the reference model, with periodic resets.
    for (int n = 0; n < 450; n++) begin
      if (n % 150 == 149) begin
        doReset();
      end
      pl.delete();
      for (int r = 1; r < 32; r++) if (pend[r]) pl.push_back(r);
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.aluV    = ($urandom_range(0, 1) == 1);
      v.aluRd   = 5'($urandom_range(0, 7));
      v.aluData = $urandom;
      v.iss     = ($urandom_range(0, 3) == 0);
      v.issRd   = 5'($urandom_range(0, 7));
      v.luV     = ($urandom_range(0, 2) == 0);
      if (pl.size() > 0 && $urandom_range(0, 4) != 0)
        v.luRd  = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        v.luRd  = 5'($urandom_range(0, 7));
      v.luData  = $urandom;
      v.rs1     = 5'($urandom_range(0, 7));
      v.rs2     = 5'($urandom_range(0, 7));
      v.rd      = 5'($urandom_range(0, 7));
      v.rdWe    = ($urandom_range(0, 1) == 1);
      applyStimulus(v);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
